// File: rtl/cpu_pkg.sv
// Shared types and encodings for the CR16-subset sequencer.
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        CLS_ALU_R,
        CLS_ALU_I,
        CLS_LOAD,
        CLS_STOR,
        CLS_JUC,
        CLS_HALT,
        CLS_NOP
    } iclass_e;

    localparam logic [3:0]  OP_RTYPE  = 4'h0;
    localparam logic [3:0]  OP_MEMJ   = 4'h4;
    localparam logic [3:0]  EXT_LOAD  = 4'h0;
    localparam logic [3:0]  EXT_STOR  = 4'h4;
    localparam logic [3:0]  EXT_JCOND = 4'hC;
    localparam logic [3:0]  COND_UC   = 4'hE;
    localparam logic [15:0] HALT_WORD = 16'hFFFF;

    // Immediate ALU opcodes: everything except R-type, the memory/jump group and 4'hF.
    function automatic logic is_imm_op(input logic [3:0] op);
        return (op != OP_RTYPE) && (op != OP_MEMJ) && (op != 4'hF);
    endfunction

endpackage

// File: rtl/inst_decode.sv
// Combinational instruction decode: class, ALU opcode and register/immediate fields.
module inst_decode
    import cpu_pkg::*;
(
    input  logic [15:0] ir_i,
    output iclass_e     iclass_o,
    output logic [7:0]  opcode_o,
    output logic        r_i_o,
    output logic [3:0]  rdest_o,
    output logic [3:0]  rsrc_o,
    output logic [7:0]  imm_o
);

    logic [3:0] op;
    logic [3:0] ext;

    assign op      = ir_i[15:12];
    assign ext     = ir_i[7:4];
    assign rdest_o = ir_i[11:8];
    assign rsrc_o  = ir_i[3:0];
    assign imm_o   = ir_i[7:0];

    // Classify the instruction; HALT_WORD is checked first since its op (4'hF) is otherwise a NOP.
    always_comb begin
        iclass_o = CLS_NOP;
        opcode_o = {op, ext};
        r_i_o    = 1'b0;
        if (ir_i == HALT_WORD) begin
            iclass_o = CLS_HALT;
        end else if (op == OP_RTYPE) begin
            iclass_o = CLS_ALU_R;
        end else if (is_imm_op(op)) begin
            iclass_o = CLS_ALU_I;
            opcode_o = {op, 4'h0};
            r_i_o    = 1'b1;
        end else if (op == OP_MEMJ) begin
            case (ext)
                EXT_LOAD:  iclass_o = CLS_LOAD;
                EXT_STOR:  iclass_o = CLS_STOR;
                EXT_JCOND: if (ir_i[11:8] == COND_UC) iclass_o = CLS_JUC;
                default:   iclass_o = CLS_NOP;
            endcase
        end
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer: owns the IR and the BRAM wait counter.
//
// state  | meaning
// FETCH  | BRAM read of PC; waits MEM_LAT cycles (held by stall), latches IR on exit
// DECODE | one cycle, pick path from instruction class
// EXEC   | ALU write-back / NOP / JUC PC load
// MEM    | MEM_LAT cycles of port-B access; STOR writes in first cycle
// WB     | LOAD write-back from port-B data
// HALT   | parked until rst
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] mem_dout,
    input  logic        stall,
    output logic        PCe,
    output logic        pc_ld,
    output logic        Ren,
    output logic [3:0]  Rdest,
    output logic [3:0]  Rsrc,
    output logic        R_I,
    output logic [7:0]  Opcode,
    output logic [7:0]  Imm,
    output logic        wb_sel,
    output logic        mem_we_b,
    output logic        halted,
    output logic [2:0]  state
);

    localparam logic [1:0] CNT_LAST = 2'(MEM_LAT - 1);

    state_e      state_q, state_d;
    logic [15:0] ir_q, ir_d;
    logic [1:0]  cnt_q, cnt_d;
    iclass_e     iclass;
    logic        cnt_done;

    inst_decode u_dec (
        .ir_i     (ir_q),
        .iclass_o (iclass),
        .opcode_o (Opcode),
        .r_i_o    (R_I),
        .rdest_o  (Rdest),
        .rsrc_o   (Rsrc),
        .imm_o    (Imm)
    );

    assign state    = state_q;
    assign cnt_done = (cnt_q == CNT_LAST);

    // State, IR and wait-counter registers; rst overrides any pending transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
            ir_q    <= 16'h0000;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and control pulses; the counter is shared by FETCH and MEM and cleared on exit.
    always_comb begin
        state_d  = state_q;
        ir_d     = ir_q;
        cnt_d    = cnt_q;
        PCe      = 1'b0;
        pc_ld    = 1'b0;
        Ren      = 1'b0;
        wb_sel   = 1'b0;
        mem_we_b = 1'b0;
        halted   = 1'b0;
        case (state_q)
            ST_FETCH: begin
                if (!stall) begin
                    if (cnt_done) begin
                        ir_d    = mem_dout;
                        cnt_d   = 2'd0;
                        state_d = ST_DECODE;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
            end
            ST_DECODE: begin
                case (iclass)
                    CLS_LOAD, CLS_STOR: state_d = ST_MEM;
                    CLS_HALT:           state_d = ST_HALT;
                    default:            state_d = ST_EXEC;
                endcase
            end
            ST_EXEC: begin
                case (iclass)
                    CLS_ALU_R, CLS_ALU_I: begin
                        Ren = 1'b1;
                        PCe = 1'b1;
                    end
                    CLS_JUC: pc_ld = 1'b1;
                    default: PCe   = 1'b1;
                endcase
                state_d = ST_FETCH;
            end
            ST_MEM: begin
                wb_sel = 1'b1;
                if (iclass == CLS_STOR && cnt_q == 2'd0) mem_we_b = 1'b1;
                if (cnt_done) begin
                    cnt_d = 2'd0;
                    if (iclass == CLS_STOR) begin
                        PCe     = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            ST_WB: begin
                Ren     = 1'b1;
                wb_sel  = 1'b1;
                PCe     = 1'b1;
                state_d = ST_FETCH;
            end
            ST_HALT: halted = 1'b1;
            default: state_d = ST_FETCH;
        endcase
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer at MEM_LAT = 1 and MEM_LAT = 2.
module tb_cpu_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic [15:0] mem_dout = 16'h0000;
    logic        sel = 1'b0;

    int checks = 0;
    int failures = 0;

    logic        a_pce, a_pcl, a_ren, a_r_i, a_wb, a_we, a_halt;
    logic [3:0]  a_rd, a_rs;
    logic [7:0]  a_opc, a_imm;
    logic [2:0]  a_st;
    logic        b_pce, b_pcl, b_ren, b_r_i, b_wb, b_we, b_halt;
    logic [3:0]  b_rd, b_rs;
    logic [7:0]  b_opc, b_imm;
    logic [2:0]  b_st;

    always #5 clk = ~clk;

    cpu_sequencer #(.MEM_LAT(1)) dut_a (
        .clk(clk), .rst(rst), .mem_dout(mem_dout), .stall(stall),
        .PCe(a_pce), .pc_ld(a_pcl), .Ren(a_ren), .Rdest(a_rd), .Rsrc(a_rs),
        .R_I(a_r_i), .Opcode(a_opc), .Imm(a_imm), .wb_sel(a_wb),
        .mem_we_b(a_we), .halted(a_halt), .state(a_st)
    );

    cpu_sequencer #(.MEM_LAT(2)) dut_b (
        .clk(clk), .rst(rst), .mem_dout(mem_dout), .stall(stall),
        .PCe(b_pce), .pc_ld(b_pcl), .Ren(b_ren), .Rdest(b_rd), .Rsrc(b_rs),
        .R_I(b_r_i), .Opcode(b_opc), .Imm(b_imm), .wb_sel(b_wb),
        .mem_we_b(b_we), .halted(b_halt), .state(b_st)
    );

    // Observed control vector {state, PCe, pc_ld, Ren, wb_sel, mem_we_b, halted}
    // and field vector {Opcode, R_I, Rdest, Rsrc, Imm} of the selected instance.
    logic [8:0]  ctl;
    logic [24:0] fld;
    assign ctl = sel ? {b_st, b_pce, b_pcl, b_ren, b_wb, b_we, b_halt}
                     : {a_st, a_pce, a_pcl, a_ren, a_wb, a_we, a_halt};
    assign fld = sel ? {b_opc, b_r_i, b_rd, b_rs, b_imm}
                     : {a_opc, a_r_i, a_rd, a_rs, a_imm};

    localparam int C_ALU = 0, C_NOP = 1, C_JUC = 2, C_LOAD = 3, C_STOR = 4, C_HALT = 5;

    function automatic logic [8:0] mk(input int st, input bit pce, input bit pcl,
                                      input bit ren, input bit wb, input bit we, input bit h);
        return {3'(st), pce, pcl, ren, wb, we, h};
    endfunction

    function automatic int model_class(input logic [15:0] w);
        int op, ext, rd;
        op  = int'(w[15:12]);
        ext = int'(w[7:4]);
        rd  = int'(w[11:8]);
        if (w == 16'hFFFF) return C_HALT;
        if (op == 0) return C_ALU;
        if (op >= 1 && op <= 14 && op != 4) return C_ALU;
        if (op == 4) begin
            if (ext == 0) return C_LOAD;
            if (ext == 4) return C_STOR;
            if (ext == 12 && rd == 14) return C_JUC;
        end
        return C_NOP;
    endfunction

    function automatic logic [15:0] rand_instr();
        logic [15:0] w;
        logic [3:0]  op;
        w = 16'($urandom);
        case ($urandom_range(0, 5))
            0: w[15:12] = 4'h0;
            1: begin
                op = 4'($urandom_range(1, 14));
                if (op == 4'h4) op = 4'h9;
                w[15:12] = op;
            end
            2: begin w[15:12] = 4'h4; w[7:4] = 4'h0; end
            3: begin w[15:12] = 4'h4; w[7:4] = 4'h4; end
            4: begin w[15:12] = 4'h4; w[11:8] = 4'hE; w[7:4] = 4'hC; end
            default: if (w == 16'hFFFF) w = 16'hFFFE;
        endcase
        return w;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        stall = 1'b0;
        step();
        rst = 1'b0;
        chk("reset_ctl", 32'(ctl), 32'(mk(0, 0, 0, 0, 0, 0, 0)));
        chk("reset_fields", 32'(fld), 32'h0);
    endtask

    // Runs one instruction from FETCH entry, comparing every cycle against a trace
    // built from the instruction class, the latency and the number of stalled cycles.
    task automatic run_instr(input string tag, input logic [15:0] w, input int lat, input int nstall);
        logic [8:0]  q[$];
        logic [24:0] exp_f;
        int cls, dec_idx, op;
        cls = model_class(w);
        op  = int'(w[15:12]);
        repeat (nstall + lat) q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        dec_idx = q.size();
        q.push_back(mk(1, 0, 0, 0, 0, 0, 0));
        case (cls)
            C_ALU:  q.push_back(mk(2, 1, 0, 1, 0, 0, 0));
            C_NOP:  q.push_back(mk(2, 1, 0, 0, 0, 0, 0));
            C_JUC:  q.push_back(mk(2, 0, 1, 0, 0, 0, 0));
            C_STOR: for (int k = 0; k < lat; k++) q.push_back(mk(3, k == lat - 1, 0, 0, 1, k == 0, 0));
            C_LOAD: begin
                for (int k = 0; k < lat; k++) q.push_back(mk(3, 0, 0, 0, 1, 0, 0));
                q.push_back(mk(4, 1, 0, 1, 1, 0, 0));
            end
            default: repeat (20) q.push_back(mk(5, 0, 0, 0, 0, 0, 1));
        endcase
        if (op == 0) exp_f = {w[15:12], w[7:4], 1'b0, w[11:8], w[3:0], w[7:0]};
        else         exp_f = {w[15:12], 4'h0, 1'b1, w[11:8], w[3:0], w[7:0]};
        mem_dout = w;
        for (int i = 0; i < q.size(); i++) begin
            if (i < nstall)           stall = 1'b1;
            else if (i < nstall + lat) stall = 1'b0;
            else                       stall = 1'($urandom);
            chk($sformatf("%s_cyc%0d", tag, i), 32'(ctl), 32'(q[i]));
            if (i == dec_idx) begin
                if (cls == C_ALU) chk({tag, "_fields"}, 32'(fld), 32'(exp_f));
                else              chk({tag, "_fields"}, 32'(fld[15:0]), 32'({w[11:8], w[3:0], w[7:0]}));
            end
            step();
        end
        stall = 1'b0;
        if (cls != C_HALT) chk({tag, "_refetch"}, 32'(ctl), 32'(mk(0, 0, 0, 0, 0, 0, 0)));
    endtask

    initial begin
        sel = 1'b0;
        do_reset();
        run_instr("add", 16'h0152, 1, 0);
        run_instr("addi", 16'h5305, 1, 0);
        run_instr("load", 16'h4405, 1, 0);
        run_instr("stor", 16'h4647, 1, 0);
        run_instr("nop", 16'h4412, 1, 0);
        run_instr("add_stall", 16'h0152, 1, 5);

        mem_dout = 16'h0152;
        step();
        chk("rstmid_decode", 32'(ctl), 32'(mk(1, 0, 0, 0, 0, 0, 0)));
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rstmid_ctl", 32'(ctl), 32'(mk(0, 0, 0, 0, 0, 0, 0)));
        chk("rstmid_ir", 32'(fld), 32'h0);

        for (int n = 0; n < 40; n++)
            run_instr($sformatf("rnd1_%0d", n), rand_instr(), 1, int'($urandom_range(0, 2)));
        run_instr("juc", 16'h4EC8, 1, 0);
        run_instr("halt", 16'hFFFF, 1, 0);

        sel = 1'b1;
        do_reset();
        run_instr("load_l2", 16'h4405, 2, 0);
        run_instr("stor_l2", 16'h4647, 2, 0);
        for (int n = 0; n < 30; n++)
            run_instr($sformatf("rnd2_%0d", n), rand_instr(), 2, int'($urandom_range(0, 2)));
        run_instr("halt_l2", 16'hFFFF, 2, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
